// File: rtl/pmips_pipe_core.sv
// pmips_pipe_core: 5-stage (IF/ID/EX/MEM/WB) pipelined PMIPS core.
// Contains the register file, an EX-stage ALU, the load-use interlock and the
// taken-branch flush.
// Configuration macro: PMIPS_FWD_EN. When it is defined, EX/MEM and MEM/WB
// results are forwarded into EX. When it is undefined, ID stalls until the
// producer has reached WB; the regfile write-through covers that case.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   imemaddr/imemrdata  instruction fetch address (= PC) / instruction word
//   dmemaddr/dmemwdata  MEM-stage address / store data
//   dmemwrite/dmemread  MEM-stage store / load enables; dmemrdata is the load data
//   aluresult           EX-stage ALU output (combinational debug tap)
//   retire              a non-bubble instruction is in WB
module pmips_pipe_core #(
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned RAW     = 3,
  parameter  int unsigned IMM_W   = 7,
  localparam int unsigned INSTR_W = 4 + 2*RAW + IMM_W
) (
  input  logic               clock,
  input  logic               reset,
  output logic [DATA_W-1:0]  imemaddr,
  input  logic [INSTR_W-1:0] imemrdata,
  output logic [DATA_W-1:0]  dmemaddr,
  output logic [DATA_W-1:0]  dmemwdata,
  output logic               dmemwrite,
  output logic               dmemread,
  input  logic [DATA_W-1:0]  dmemrdata,
  output logic [DATA_W-1:0]  aluresult,
  output logic               retire
);
  localparam int unsigned NREG = 1 << RAW;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4, OP_ADDI = 4'd5, OP_LW = 4'd6, OP_SW = 4'd7;
  localparam logic [3:0] OP_BEQ = 4'd8, OP_JMP = 4'd9, OP_NOP = 4'hF;
  localparam logic [INSTR_W-1:0] INSTR_NOP = {OP_NOP, (INSTR_W-4)'(0)};

  logic [DATA_W-1:0]  pc_q, pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_W-1:0]  ifid_pcp2_q, ifid_pcp2_d;
  logic               idex_valid_q, idex_valid_d, idex_wen_q, idex_wen_d;
  logic [3:0]         idex_op_q, idex_op_d;
  logic [RAW-1:0]     idex_dst_q, idex_dst_d;
  logic [DATA_W-1:0]  idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [DATA_W-1:0]  idex_imm_q, idex_imm_d, idex_pcp2_q, idex_pcp2_d;
`ifdef PMIPS_FWD_EN
  logic [RAW-1:0]     idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d;
`endif
  logic               exmem_valid_q, exmem_valid_d, exmem_wen_q, exmem_wen_d;
  logic               exmem_memw_q, exmem_memw_d, exmem_memr_q, exmem_memr_d;
  logic [RAW-1:0]     exmem_dst_q, exmem_dst_d;
  logic [DATA_W-1:0]  exmem_res_q, exmem_res_d, exmem_wdata_q, exmem_wdata_d;
  logic               memwb_valid_q, memwb_valid_d, memwb_wen_q, memwb_wen_d;
  logic [RAW-1:0]     memwb_dst_q, memwb_dst_d;
  logic [DATA_W-1:0]  memwb_val_q, memwb_val_d;
  logic [DATA_W-1:0]  rf_q [NREG];
  logic [DATA_W-1:0]  rf_d [NREG];

  logic [3:0]         id_op;
  logic [RAW-1:0]     id_rs, id_rt, id_dst;
  logic [IMM_W-1:0]   id_imm;
  logic [DATA_W-1:0]  id_a, id_b;
  logic               id_wen, hz_ex, stall;
  logic [DATA_W-1:0]  ex_a, ex_b, ex_alu, ex_target;
  logic               ex_taken;

  // Register file: WB write, R0 hard-wired to zero.
  always_comb begin
    rf_d = rf_q;
    if (memwb_wen_q && memwb_dst_q != '0) rf_d[memwb_dst_q] = memwb_val_q;
  end

  // ID decode, register read with write-through from WB, interlock.
  always_comb begin
    id_op  = ifid_instr_q[INSTR_W-1 -: 4];
    id_rs  = ifid_instr_q[INSTR_W-5 -: RAW];
    id_rt  = ifid_instr_q[INSTR_W-5-RAW -: RAW];
    id_imm = ifid_instr_q[IMM_W-1:0];
    id_wen = (id_op <= OP_LW);
    id_dst = (id_op <= OP_SLT) ? id_imm[IMM_W-1 -: RAW] : id_rt;
    id_a   = (memwb_wen_q && memwb_dst_q != '0 && memwb_dst_q == id_rs) ? memwb_val_q : rf_q[id_rs];
    id_b   = (memwb_wen_q && memwb_dst_q != '0 && memwb_dst_q == id_rt) ? memwb_val_q : rf_q[id_rt];
    hz_ex  = idex_wen_q && idex_dst_q != '0 && (idex_dst_q == id_rs || idex_dst_q == id_rt);
`ifdef PMIPS_FWD_EN
    stall  = ifid_valid_q && hz_ex && (idex_op_q == OP_LW);
`else
    // Without forwarding, wait until the producer has left MEM.
    stall  = ifid_valid_q && (hz_ex || (exmem_wen_q && exmem_dst_q != '0 &&
             (exmem_dst_q == id_rs || exmem_dst_q == id_rt)));
`endif
  end

  // EX operand selection: EX/MEM has priority over MEM/WB.
  always_comb begin
    ex_a = idex_a_q;
    ex_b = idex_b_q;
`ifdef PMIPS_FWD_EN
    if (exmem_wen_q && exmem_dst_q != '0 && exmem_dst_q == idex_rs_q) ex_a = exmem_res_q;
    else if (memwb_wen_q && memwb_dst_q != '0 && memwb_dst_q == idex_rs_q) ex_a = memwb_val_q;
    if (exmem_wen_q && exmem_dst_q != '0 && exmem_dst_q == idex_rt_q) ex_b = exmem_res_q;
    else if (memwb_wen_q && memwb_dst_q != '0 && memwb_dst_q == idex_rt_q) ex_b = memwb_val_q;
`endif
  end

  // EX ALU and branch resolution.
  always_comb begin
    ex_alu = '0;
    case (idex_op_q)
      OP_ADD:                 ex_alu = ex_a + ex_b;
      OP_SUB:                 ex_alu = ex_a - ex_b;
      OP_AND:                 ex_alu = ex_a & ex_b;
      OP_OR:                  ex_alu = ex_a | ex_b;
      OP_SLT:                 ex_alu = DATA_W'($signed(ex_a) < $signed(ex_b));
      OP_ADDI, OP_LW, OP_SW:  ex_alu = ex_a + idex_imm_q;
      default:                ex_alu = '0;
    endcase
    ex_taken  = idex_valid_q && (idex_op_q == OP_JMP || (idex_op_q == OP_BEQ && ex_a == ex_b));
    ex_target = (idex_pcp2_q + (idex_imm_q << 1)) & ~DATA_W'(1);
  end

  // Pipeline advance; a taken branch overrides a stall.
  always_comb begin
    pc_d          = pc_q + DATA_W'(2);
    ifid_valid_d  = 1'b1;
    ifid_instr_d  = imemrdata;
    ifid_pcp2_d   = pc_q + DATA_W'(2);
    idex_valid_d  = ifid_valid_q;
    idex_wen_d    = ifid_valid_q && id_wen;
    idex_op_d     = id_op;
    idex_dst_d    = id_dst;
    idex_a_d      = id_a;
    idex_b_d      = id_b;
    idex_imm_d    = {{(DATA_W-IMM_W){id_imm[IMM_W-1]}}, id_imm};
    idex_pcp2_d   = ifid_pcp2_q;
`ifdef PMIPS_FWD_EN
    idex_rs_d     = id_rs;
    idex_rt_d     = id_rt;
`endif
    if (ex_taken || stall) begin
      idex_valid_d = 1'b0;
      idex_wen_d   = 1'b0;
      idex_op_d    = OP_NOP;
    end
    if (ex_taken) begin
      pc_d         = ex_target;
      ifid_valid_d = 1'b0;
      ifid_instr_d = INSTR_NOP;
    end else if (stall) begin
      pc_d         = pc_q;
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pcp2_d  = ifid_pcp2_q;
    end
    exmem_valid_d = idex_valid_q;
    exmem_wen_d   = idex_wen_q;
    exmem_dst_d   = idex_dst_q;
    exmem_res_d   = ex_alu;
    exmem_wdata_d = ex_b;
    exmem_memw_d  = idex_valid_q && (idex_op_q == OP_SW);
    exmem_memr_d  = idex_valid_q && (idex_op_q == OP_LW);
    memwb_valid_d = exmem_valid_q;
    memwb_wen_d   = exmem_wen_q;
    memwb_dst_d   = exmem_dst_q;
    memwb_val_d   = exmem_memr_q ? dmemrdata : exmem_res_q;
  end

  // State registers; reset empties every stage and clears the register file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      ifid_valid_q <= 1'b0; ifid_instr_q <= INSTR_NOP; ifid_pcp2_q <= '0;
      idex_valid_q <= 1'b0; idex_wen_q <= 1'b0; idex_op_q <= OP_NOP; idex_dst_q <= '0;
      idex_a_q <= '0; idex_b_q <= '0; idex_imm_q <= '0; idex_pcp2_q <= '0;
`ifdef PMIPS_FWD_EN
      idex_rs_q <= '0; idex_rt_q <= '0;
`endif
      exmem_valid_q <= 1'b0; exmem_wen_q <= 1'b0; exmem_memw_q <= 1'b0; exmem_memr_q <= 1'b0;
      exmem_dst_q <= '0; exmem_res_q <= '0; exmem_wdata_q <= '0;
      memwb_valid_q <= 1'b0; memwb_wen_q <= 1'b0; memwb_dst_q <= '0; memwb_val_q <= '0;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      ifid_valid_q <= ifid_valid_d; ifid_instr_q <= ifid_instr_d; ifid_pcp2_q <= ifid_pcp2_d;
      idex_valid_q <= idex_valid_d; idex_wen_q <= idex_wen_d; idex_op_q <= idex_op_d;
      idex_dst_q <= idex_dst_d; idex_a_q <= idex_a_d; idex_b_q <= idex_b_d;
      idex_imm_q <= idex_imm_d; idex_pcp2_q <= idex_pcp2_d;
`ifdef PMIPS_FWD_EN
      idex_rs_q <= idex_rs_d; idex_rt_q <= idex_rt_d;
`endif
      exmem_valid_q <= exmem_valid_d; exmem_wen_q <= exmem_wen_d; exmem_memw_q <= exmem_memw_d;
      exmem_memr_q <= exmem_memr_d; exmem_dst_q <= exmem_dst_d; exmem_res_q <= exmem_res_d;
      exmem_wdata_q <= exmem_wdata_d;
      memwb_valid_q <= memwb_valid_d; memwb_wen_q <= memwb_wen_d; memwb_dst_q <= memwb_dst_d;
      memwb_val_q <= memwb_val_d;
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= rf_d[i];
    end
  end

  assign imemaddr  = pc_q;
  assign dmemaddr  = exmem_res_q;
  assign dmemwdata = exmem_wdata_q;
  assign dmemwrite = exmem_memw_q;
  assign dmemread  = exmem_memr_q;
  assign aluresult = ex_alu;
  assign retire    = memwb_valid_q;

endmodule

// File: tb/tb_pmips_pipe_core.sv
// Testbench for pmips_pipe_core at default parameters. It holds the
// instruction and data memories. Directed programs are listed in a vector
// table and checked through the final register value; hand-written sequences
// cover pipeline timing, the load-use stall, branch kills, stores and a reset
// taken mid-operation.
module tb_pmips_pipe_core;
  localparam logic [16:0] NOP = 17'h1E000;

  typedef struct packed {
    logic [7:0][16:0] prog;
    logic [2:0]       reg_idx;
    logic [15:0]      exp;
  } vec_t;

  logic        clock, reset;
  logic [15:0] imemaddr, dmemaddr, dmemwdata, dmemrdata, aluresult;
  logic [16:0] imemrdata;
  logic        dmemwrite, dmemread, retire;
  logic        dm_clear;
  logic [16:0] imem [64];
  logic [15:0] dmem [64];
  int          errors, checks;
  vec_t        vec [16];

  pmips_pipe_core dut (
    .clock(clock), .reset(reset), .imemaddr(imemaddr), .imemrdata(imemrdata),
    .dmemaddr(dmemaddr), .dmemwdata(dmemwdata), .dmemwrite(dmemwrite),
    .dmemread(dmemread), .dmemrdata(dmemrdata), .aluresult(aluresult), .retire(retire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign imemrdata = (imemaddr[15:7] == '0 && !imemaddr[0]) ? imem[imemaddr[6:1]] : NOP;
  assign dmemrdata = (dmemaddr[15:6] == '0) ? dmem[dmemaddr[5:0]] : 16'h0000;

  always @(posedge clock) begin
    if (dm_clear) begin
      for (int k = 1; k < 64; k++) dmem[k] <= 16'h0000;
      dmem[0] <= 16'h00A5;
    end else if (dmemwrite && dmemaddr[15:6] == '0) begin
      dmem[dmemaddr[5:0]] <= dmemwdata;
    end
  end

  function automatic logic [16:0] enc(input int op, input int rs, input int rt, input int imm);
    return {4'(op), 3'(rs), 3'(rt), 7'(imm)};
  endfunction

  function automatic logic [16:0] rtype(input int op, input int rs, input int rt, input int rd);
    return enc(op, rs, rt, rd << 4);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input logic [7:0][16:0] p);
    for (int k = 0; k < 64; k++) imem[k] = NOP;
    for (int k = 0; k < 8; k++) imem[k] = p[k];
  endtask

  // Holds reset over two edges (clearing data memory), releases on a negedge:
  // the following half cycle is cycle 0 with PC = 0.
  task automatic do_reset();
    reset = 1'b0;
    dm_clear = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    dm_clear = 1'b0;
    reset = 1'b1;
  endtask

  task automatic run_prog(input logic [7:0][16:0] p);
    reset = 1'b0;
    load_prog(p);
    do_reset();
  endtask

  // Records retire for cycles 0..9 and counts dmemread cycles over that window.
  task automatic trace(output logic [9:0] ret, output int nrd);
    ret = '0;
    nrd = 0;
    #1;
    ret[0] = retire;
    for (int c = 1; c < 10; c++) begin
      @(posedge clock); #1;
      ret[c] = retire;
      if (dmemread) nrd++;
    end
  endtask

  initial begin
    logic [9:0] ret;
    int nrd, nwr, budget;
    logic [15:0] waddr, wdata;
    errors = 0;
    checks = 0;
    reset = 1'b0;
    dm_clear = 1'b1;

    for (int i = 0; i < 16; i++) begin
      vec[i].prog = {8{NOP}};
      vec[i].reg_idx = 3'd0;
      vec[i].exp = 16'h0;
    end
    // ADD / SUB / AND / OR with back-to-back dependencies.
    vec[0].prog[0] = enc(5,0,1,5);  vec[0].prog[1] = enc(5,0,2,7);  vec[0].prog[2] = rtype(0,1,2,3);
    vec[0].reg_idx = 3; vec[0].exp = 16'h000C;
    vec[1].prog[0] = enc(5,0,1,5);  vec[1].prog[1] = enc(5,0,2,7);  vec[1].prog[2] = rtype(1,1,2,3);
    vec[1].reg_idx = 3; vec[1].exp = 16'hFFFE;
    vec[2].prog[0] = enc(5,0,1,12); vec[2].prog[1] = enc(5,0,2,10); vec[2].prog[2] = rtype(2,1,2,3);
    vec[2].reg_idx = 3; vec[2].exp = 16'h0008;
    vec[3].prog[0] = enc(5,0,1,12); vec[3].prog[1] = enc(5,0,2,10); vec[3].prog[2] = rtype(3,1,2,3);
    vec[3].reg_idx = 3; vec[3].exp = 16'h000E;
    // SLT is signed: -1 < 1.
    vec[4].prog[0] = enc(5,0,1,7'h7F); vec[4].prog[1] = enc(5,0,2,1); vec[4].prog[2] = rtype(4,1,2,3);
    vec[4].reg_idx = 3; vec[4].exp = 16'h0001;
    vec[5].prog[0] = enc(5,0,1,7'h7F); vec[5].prog[1] = enc(5,0,2,1); vec[5].prog[2] = rtype(4,2,1,3);
    vec[5].prog[3] = enc(5,3,4,6);
    vec[5].reg_idx = 4; vec[5].exp = 16'h0006;
    // R0 is never written nor forwarded.
    vec[6].prog[0] = enc(5,0,0,7); vec[6].prog[1] = rtype(0,0,0,2); vec[6].prog[2] = enc(5,2,2,3);
    vec[6].reg_idx = 2; vec[6].exp = 16'h0003;
    vec[7].prog[0] = enc(5,0,1,7'h7F);
    vec[7].reg_idx = 1; vec[7].exp = 16'hFFFF;
    // Load-use.
    vec[8].prog[0] = enc(6,0,1,0); vec[8].prog[1] = rtype(0,1,1,2);
    vec[8].reg_idx = 2; vec[8].exp = 16'h014A;
    // Chained ADDI: the youngest producer must win.
    vec[9].prog[0] = enc(5,0,1,1); vec[9].prog[1] = enc(5,1,1,2); vec[9].prog[2] = enc(5,1,1,4);
    vec[9].reg_idx = 1; vec[9].exp = 16'h0007;
    // Taken BEQ, target at index 4.
    vec[10].prog[0] = enc(5,0,1,3); vec[10].prog[1] = enc(8,1,1,2);
    vec[10].prog[2] = enc(5,0,4,9); vec[10].prog[3] = enc(5,0,5,9); vec[10].prog[4] = enc(5,0,6,9);
    vec[10].reg_idx = 6; vec[10].exp = 16'h0009;
    // Not-taken BEQ.
    vec[11].prog[0] = enc(5,0,1,3); vec[11].prog[1] = enc(8,1,0,2); vec[11].prog[2] = enc(5,0,4,9);
    vec[11].reg_idx = 4; vec[11].exp = 16'h0009;
    // JMP kills the next instruction.
    vec[12].prog[0] = enc(9,0,0,1); vec[12].prog[1] = enc(5,0,2,1); vec[12].prog[2] = enc(5,2,2,4);
    vec[12].reg_idx = 2; vec[12].exp = 16'h0004;
    // LW, SW of the loaded value, LW back.
    vec[13].prog[0] = enc(6,0,1,0); vec[13].prog[1] = enc(7,0,1,8); vec[13].prog[2] = enc(6,0,2,8);
    vec[13].reg_idx = 2; vec[13].exp = 16'h00A5;
    vec[14].prog[0] = enc(6,0,1,0); vec[14].prog[1] = enc(5,1,2,1);
    vec[14].reg_idx = 2; vec[14].exp = 16'h00A6;
    // Branch in EX while ID is stalled or dependent: the ID instruction is killed.
    vec[15].prog[0] = enc(5,0,1,1); vec[15].prog[1] = enc(8,0,0,1); vec[15].prog[2] = rtype(0,1,1,2);
    vec[15].prog[3] = enc(5,1,3,4); vec[15].prog[4] = enc(5,2,2,2);
    vec[15].reg_idx = 2; vec[15].exp = 16'h0002;

    for (int i = 0; i < 16; i++) begin
      run_prog(vec[i].prog);
      repeat (24) @(posedge clock);
      #1;
      check($sformatf("vec%0d_r%0d", i, vec[i].reg_idx), 32'(dut.rf_q[vec[i].reg_idx]), 32'(vec[i].exp));
    end

    // Fill timing of three dependent ADDIs/ADD.
    run_prog(vec[0].prog);
    check("t1_pc0", 32'(imemaddr), 32'h0);
    trace(ret, nrd);
`ifdef PMIPS_FWD_EN
    check("t1_retire", 32'(ret), 32'(10'b1111110000));
`else
    check("t1_retire", 32'(ret), 32'(10'b1100110000));
`endif

    // Load-use interlock and single-cycle dmemread.
    run_prog(vec[8].prog);
    trace(ret, nrd);
`ifdef PMIPS_FWD_EN
    check("t2_retire", 32'(ret), 32'(10'b1111010000));
`else
    check("t2_retire", 32'(ret), 32'(10'b1110010000));
`endif
    check("t2_dmemread_cycles", 32'(nrd), 32'd1);

    // Both instructions behind the taken branch leave no trace.
    run_prog(vec[10].prog);
    repeat (24) @(posedge clock);
    #1;
    check("t3_r4_killed", 32'(dut.rf_q[4]), 32'h0);
    check("t3_r5_killed", 32'(dut.rf_q[5]), 32'h0);

    // Store of -1 to address 4.
    vec[0].prog = {8{NOP}};
    vec[0].prog[0] = enc(5,0,1,7'h7F);
    vec[0].prog[1] = enc(7,0,1,4);
    run_prog(vec[0].prog);
    nwr = 0; waddr = 16'h0; wdata = 16'h0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (dmemwrite) begin
        nwr++;
        waddr = dmemaddr;
        wdata = dmemwdata;
      end
    end
    check("t4_write_cycles", 32'(nwr), 32'd1);
    check("t4_dmemaddr", 32'(waddr), 32'h4);
    check("t4_dmemwdata", 32'(wdata), 32'hFFFF);
    check("t4_mem4", 32'(dmem[4]), 32'hFFFF);

    // Reset while the store is in MEM.
    run_prog(vec[0].prog);
    budget = 20;
    @(posedge clock); #1;
    while (!dmemwrite && budget > 0) begin
      @(posedge clock); #1;
      budget--;
    end
    check("t6_store_seen", 32'(dmemwrite), 32'h1);
    reset = 1'b0;
    #1;
    check("t6_dmemwrite", 32'(dmemwrite), 32'h0);
    check("t6_pc", 32'(imemaddr), 32'h0);
    check("t6_retire", 32'(retire), 32'h0);
    check("t6_outs", {dmemaddr, dmemwdata}, 32'h0);
    check("t6_aluresult", 32'(aluresult), 32'h0);
    check("t6_rf1_cleared", 32'(dut.rf_q[1]), 32'h0);
    @(posedge clock); #1;
    check("t6_mem4_suppressed", 32'(dmem[4]), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("t6_refetch_pc", 32'(imemaddr), 32'h0);
    repeat (20) @(posedge clock);
    #1;
    check("t6_refetch_store", 32'(dmem[4]), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
